// File: rtl/apb_regfile_pkg.sv
// Shared types and helpers for the parametrised APB4 register-file slave.
package apb_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        NONE,
        MISALIGN,
        RANGE,
        RO,
        RDSTRB,
        LOCK
    } err_e;

    // Wait counter covers WAIT_CYCLES 0..15
    localparam int unsigned CNT_W = 4;

    function automatic int unsigned strb_w(input int unsigned dw);
        return dw / 8;
    endfunction

    function automatic int unsigned idx_shift(input int unsigned dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/apb_regfile_mem.sv
// DEPTH x DATA_W register storage: byte-strobed synchronous write, combinational read.
module apb_regfile_mem #(
    parameter int unsigned         DATA_W    = 32,
    parameter int unsigned         DEPTH     = 16,
    parameter int unsigned         IDX_W     = 4,
    parameter logic [DATA_W-1:0]   RESET_VAL = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DATA_W/8-1:0]   i_wstrb,
    input  logic [IDX_W-1:0]      i_raddr,
    output logic [DATA_W-1:0]     o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_VAL;
            end
        end else if (i_we) begin
            for (int unsigned k = 0; k < DATA_W / 8; k++) begin
                if (i_wstrb[k]) begin
                    r_mem[i_waddr][k*8 +: 8] <= i_wdata[k*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = (32'(i_raddr) < DEPTH) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/apb_regfile_slave_p.sv
// Parametrised APB4 slave with register file, wait states, byte strobes and PSLVERR.
// Optional: define APB_REGFILE_LOCK_EN to make register DEPTH-1 a sticky write-lock.
module apb_regfile_slave_p
    import apb_regfile_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       DEPTH       = 16,
    parameter int unsigned       WAIT_CYCLES = 0,
    parameter logic [DEPTH-1:0]  RO_MASK     = '0,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic                PSELx,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W/8-1:0] PSTRB,
    output logic                PREADY,
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PSLVERR
);

    localparam int unsigned STRB_W = strb_w(DATA_W);
    localparam int unsigned SHIFT  = idx_shift(DATA_W);
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e              r_state, w_state_nx;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
    logic [ADDR_W-1:0]   r_paddr;
    logic                r_pwrite;
    logic [DATA_W-1:0]   r_pwdata;
    logic [STRB_W-1:0]   r_pstrb;
    logic                r_pready, r_pslverr;
    logic [DATA_W-1:0]   r_prdata;
    logic                w_pready_nx, w_pslverr_nx, w_latch, w_finish;
    logic [DATA_W-1:0]   w_prdata_nx;

    // With zero wait states the decision is made in IDLE, before the latch holds the request
    logic [ADDR_W-1:0]   w_addr;
    logic                w_write;
    logic [STRB_W-1:0]   w_strb;
    logic [ADDR_W-1:0]   w_idx_full;
    logic [IDX_W-1:0]    w_idx;
    logic [DATA_W-1:0]   w_mem_rdata, w_rd_val;
    logic                w_misalign, w_range, w_ro, w_is_last, w_we, w_mem_we;
    err_e                w_cause;

    assign w_addr     = (r_state == IDLE) ? PADDR  : r_paddr;
    assign w_write    = (r_state == IDLE) ? PWRITE : r_pwrite;
    assign w_strb     = (r_state == IDLE) ? PSTRB  : r_pstrb;
    assign w_idx_full = w_addr >> SHIFT;
    assign w_idx      = w_idx_full[IDX_W-1:0];
    assign w_misalign = (w_addr & ADDR_W'((1 << SHIFT) - 1)) != '0;
    assign w_range    = 32'(w_idx_full) >= DEPTH;
    assign w_is_last  = 32'(w_idx_full) == (DEPTH - 1);
    assign w_we       = (r_state == DONE) && PSELx && r_pwrite && !r_pslverr;

`ifdef APB_REGFILE_LOCK_EN
    logic r_lock;

    assign w_ro     = RO_MASK[w_idx] && !w_is_last;
    assign w_rd_val = w_is_last ? {{(DATA_W-1){1'b0}}, r_lock} : w_mem_rdata;
    assign w_mem_we = w_we && !w_is_last;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_lock <= 1'b0;
        end else if (w_we && w_is_last && r_pstrb[0] && r_pwdata[0]) begin
            r_lock <= 1'b1;
        end
    end
`else
    assign w_ro     = RO_MASK[w_idx];
    assign w_rd_val = w_mem_rdata;
    assign w_mem_we = w_we;
`endif

    always_comb begin
        w_cause = NONE;
        if (w_misalign) begin
            w_cause = MISALIGN;
        end else if (w_range) begin
            w_cause = RANGE;
        end else if (w_write && w_ro) begin
            w_cause = RO;
        end else if (!w_write && (w_strb != '0)) begin
            w_cause = RDSTRB;
`ifdef APB_REGFILE_LOCK_EN
        end else if (w_write && r_lock && !w_is_last) begin
            w_cause = LOCK;
`endif
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_latch      = 1'b0;
        w_finish     = 1'b0;
        w_pready_nx  = 1'b0;
        w_pslverr_nx = 1'b0;
        w_prdata_nx  = '0;
        case (r_state)
            IDLE: begin
                if (PSELx && !PENABLE) begin
                    w_latch  = 1'b1;
                    w_cnt_nx = CNT_W'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        w_state_nx = DONE;
                        w_finish   = 1'b1;
                    end else begin
                        w_state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!PSELx) begin
                    w_state_nx = IDLE;
                end else if (PENABLE) begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) begin
                        w_state_nx = DONE;
                        w_finish   = 1'b1;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
        if (w_finish) begin
            w_pready_nx  = 1'b1;
            w_pslverr_nx = (w_cause != NONE);
            w_prdata_nx  = (!w_write && w_cause == NONE) ? w_rd_val : '0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_pready  <= w_pready_nx;
            r_pslverr <= w_pslverr_nx;
            r_prdata  <= w_prdata_nx;
            if (w_latch) begin
                r_paddr  <= PADDR;
                r_pwrite <= PWRITE;
                r_pwdata <= PWDATA;
                r_pstrb  <= PSTRB;
            end
        end
    end

    apb_regfile_mem #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W),
        .RESET_VAL (RESET_VAL)
    ) u_mem (
        .i_clk   (PCLK),
        .i_rst   (PRESET),
        .i_we    (w_mem_we),
        .i_waddr (w_idx),
        .i_wdata (r_pwdata),
        .i_wstrb (r_pstrb),
        .i_raddr (w_idx),
        .o_rdata (w_mem_rdata)
    );

    assign PREADY  = r_pready;
    assign PRDATA  = r_prdata;
    assign PSLVERR = r_pslverr;

endmodule
